// File: rtl/sat_pkg.sv
// Shared types and saturation helpers for the saturating accumulator datapath.
// Helpers work on a wide signed value so one package serves any sample width.
package sat_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } sat_res_t;

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Clamp a sign-extended sum into the signed range of a w-bit word.
    function automatic sat_res_t saturate(input logic signed [63:0] s, input int w);
        sat_res_t r;
        r.sat = 1'b0;
        r.val = s;
        if (s > sat_max(w)) begin
            r.sat = 1'b1;
            r.val = sat_max(w);
        end else if (s < sat_min(w)) begin
            r.sat = 1'b1;
            r.val = sat_min(w);
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_addsub.sv
// Combinational signed add/subtract with clamping to the WIDTH-bit range.
// One extra bit of headroom covers every case, including 0 - MIN.
module sat_addsub
    import sat_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_y,
    output logic             o_sat
);

    logic signed [WIDTH:0] w_a;
    logic signed [WIDTH:0] w_b;
    logic signed [WIDTH:0] w_s;
    logic signed [63:0]    w_s64;
    sat_res_t              w_res;
    logic                  w_unused_hi;

    assign w_a   = {i_a[WIDTH-1], i_a};
    assign w_b   = {i_b[WIDTH-1], i_b};
    assign w_s   = i_sub ? (w_a - w_b) : (w_a + w_b);
    assign w_s64 = 64'(w_s);
    assign w_res = saturate(w_s64, WIDTH);

    assign o_y         = w_res.val[WIDTH-1:0];
    assign o_sat       = w_res.sat;
    assign w_unused_hi = ^w_res.val[63:WIDTH];

endmodule

// File: rtl/sat_block_accumulator.sv
// Saturating block accumulator: sums len signed samples with per-sample add/sub,
// clamps every step, and presents the result plus a sticky clamp flag on ready/valid.
module sat_block_accumulator
    import sat_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat,
    output logic [WIDTH-1:0] acc_q
);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len_q;
    logic [WIDTH-1:0] r_acc;
    logic             r_sticky;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_sat;

    logic [WIDTH-1:0] w_sum;
    logic             w_step_sat;
    logic             w_accept;
    logic [CNT_W-1:0] w_len_eff;
    logic             w_last;

    sat_addsub #(.WIDTH(WIDTH)) u_addsub (
        .i_a   (r_acc),
        .i_b   (in_data),
        .i_sub (in_sub),
        .o_y   (w_sum),
        .o_sat (w_step_sat)
    );

    // rst_n gates in_ready so nothing looks acceptable while reset is held.
    assign in_ready  = rst_n & (r_state != HOLD) & ~clr;
    assign w_accept  = in_valid & in_ready;
    assign w_len_eff = (len == '0) ? CNT_W'(1) : len;
    assign out_valid = (r_state == HOLD);
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign acc_q     = r_acc;

    always_comb begin
        w_last = 1'b0;
        case (r_state)
            IDLE:    w_last = (w_len_eff == CNT_W'(1));
            ACCUM:   w_last = ((r_cnt + CNT_W'(1)) == r_len_q);
            default: w_last = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next_state = w_last ? HOLD : ACCUM;
            end
            ACCUM: begin
                if (w_accept && w_last) w_next_state = HOLD;
            end
            HOLD: begin
                if (out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
        if (clr) w_next_state = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_len_q    <= '0;
            r_sticky   <= 1'b0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else if (clr) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_len_q  <= w_len_eff;
                        r_acc    <= w_sum;
                        r_cnt    <= CNT_W'(1);
                        r_sticky <= w_step_sat;
                        if (w_last) begin
                            r_out_data <= w_sum;
                            r_out_sat  <= w_step_sat;
                        end
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        r_acc    <= w_sum;
                        r_cnt    <= r_cnt + CNT_W'(1);
                        r_sticky <= r_sticky | w_step_sat;
                        if (w_last) begin
                            r_out_data <= w_sum;
                            r_out_sat  <= r_sticky | w_step_sat;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_sticky <= 1'b0;
                    end
                end
                default: begin
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_sticky <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sat_block_accumulator.sv
// Table-driven bench for sat_block_accumulator with a scoreboard of block results.
module tb_sat_block_accumulator;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sat;
    logic [WIDTH-1:0] acc_q;

    sat_block_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .acc_q     (acc_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]            len;
        logic [2:0]            n;
        logic [0:3][15:0]      d;
        logic [0:3]            s;
        logic [0:3][15:0]      acc;
        logic [15:0]           exp_d;
        logic                  exp_s;
    } vec_t;

    typedef struct packed {
        logic [15:0] d;
        logic        s;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[7];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("sb_out_data", $signed(out_data), $signed(e.d));
                check("sb_out_sat", int'(out_sat), int'(e.s));
            end
        end
    end

    task automatic send_sample(input logic [15:0] d, input logic s, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = s;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic run_block(input vec_t v, input bit push);
        bit ok;
        len = v.len;
        if (push) sbq.push_back('{d: v.exp_d, s: v.exp_s});
        for (int i = 0; i < int'(v.n); i++) begin
            send_sample(v.d[i], v.s[i], ok);
            check("step_acc", $signed(acc_q), $signed(v.acc[i]));
            check("step_out_valid", int'(out_valid), (i == int'(v.n) - 1) ? 1 : 0);
        end
        if (out_ready) begin
            @(posedge clk);
            #1;
            check("idle_valid", int'(out_valid), 0);
            check("idle_acc", $signed(acc_q), 0);
        end
    endtask

    initial begin
        bit ok;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        vec_t v;
        vecs[0] = '{8'd4, 3'd4, '{16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000}, 4'b0000,
                    '{16'sd1000, 16'sd3000, 16'sd6000, 16'sd10000}, 16'sd10000, 1'b0};
        vecs[1] = '{8'd2, 3'd2, '{16'sd30000, 16'sd10000, 16'sd0, 16'sd0}, 4'b0000,
                    '{16'sd30000, 16'sd32767, 16'sd0, 16'sd0}, 16'sd32767, 1'b1};
        vecs[2] = '{8'd3, 3'd3, '{-16'sd20000, 16'sd20000, 16'sd100, 16'sd0}, 4'b0100,
                    '{-16'sd20000, 16'h8000, -16'sd32668, 16'sd0}, -16'sd32668, 1'b1};
        vecs[3] = '{8'd1, 3'd1, '{16'h8000, 16'sd0, 16'sd0, 16'sd0}, 4'b1000,
                    '{16'sd32767, 16'sd0, 16'sd0, 16'sd0}, 16'sd32767, 1'b1};
        vecs[4] = '{8'd0, 3'd1, '{16'sd5, 16'sd0, 16'sd0, 16'sd0}, 4'b0000,
                    '{16'sd5, 16'sd0, 16'sd0, 16'sd0}, 16'sd5, 1'b0};
        vecs[5] = '{8'd3, 3'd3, '{16'h8000, 16'sd1, 16'sd32767, 16'sd0}, 4'b0100,
                    '{16'h8000, 16'h8000, -16'sd1, 16'sd0}, -16'sd1, 1'b1};
        vecs[6] = '{8'd4, 3'd4, '{16'sd50, 16'sd50, 16'sd50, 16'sd50}, 4'b0000,
                    '{16'sd50, 16'sd100, 16'sd150, 16'sd200}, 16'sd200, 1'b0};

        rst_n = 1'b0; clr = 1'b0; len = '0; in_valid = 1'b0;
        in_data = '0; in_sub = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_acc", int'(acc_q), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_sat", int'(out_sat), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 6; i++) run_block(vecs[i], 1'b1);

        // Backpressure with a mid-block len change that must be ignored.
        out_ready = 1'b0;
        len = 8'd2;
        sbq.push_back('{d: 16'd12, s: 1'b0});
        send_sample(16'd5, 1'b0, ok);
        len = 8'd1;
        check("bp_not_done", int'(out_valid), 0);
        send_sample(16'd7, 1'b0, ok);
        in_valid = 1'b1; in_data = 16'd99;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", int'(out_valid), 1);
            check("bp_data", int'(out_data), 12);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_acc", int'(acc_q), 12);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", int'(out_valid), 0);
        v = '{8'd1, 3'd1, '{16'sd3, 16'sd0, 16'sd0, 16'sd0}, 4'b0000,
              '{16'sd3, 16'sd0, 16'sd0, 16'sd0}, 16'sd3, 1'b0};
        run_block(v, 1'b1);

        // clr mid-block discards partial sum.
        len = 8'd4;
        send_sample(16'd100, 1'b0, ok);
        send_sample(16'd200, 1'b0, ok);
        check("clr_pre_acc", int'(acc_q), 300);
        clr = 1'b1; in_valid = 1'b1; in_data = 16'd999;
        @(negedge clk);
        check("clr_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        check("clr_acc", int'(acc_q), 0);
        check("clr_valid", int'(out_valid), 0);
        run_block(vecs[6], 1'b1);

        // clr while a result is pending drops it.
        out_ready = 1'b0;
        len = 8'd1;
        send_sample(16'd7, 1'b0, ok);
        check("clr_hold_pre", int'(out_valid), 1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        out_ready = 1'b1;
        check("clr_hold_valid", int'(out_valid), 0);
        check("clr_hold_acc", int'(acc_q), 0);

        // Asynchronous reset mid-block.
        len = 8'd4;
        send_sample(16'd100, 1'b0, ok);
        send_sample(16'd200, 1'b0, ok);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_acc", int'(acc_q), 0);
        check("arst_valid", int'(out_valid), 0);
        check("arst_data", int'(out_data), 0);
        check("arst_sat", int'(out_sat), 0);
        check("arst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_block(vecs[6], 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
